// File: rtl/iic_vid_ramp.sv
// VID ramp sequencer: walks the MP8864 output code toward a target in clamped steps,
// one single-byte I2C write per step. Optional watchdog via `IIC_VID_RAMP_TIMEOUT_EN.
`timescale 1ns/1ps
module iic_vid_ramp #(
    parameter logic [7:0]  STEP     = 8'd4,
    parameter logic [15:0] DWELL    = 16'd5000,
    parameter logic [7:0]  VID_INIT = 8'h00,
    parameter logic [23:0] TIMEOUT  = 24'd2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target,
    input  logic       target_vld,
    output logic       target_rdy,
    output logic [7:0] iic_data,
    output logic       iic_start,
    input  logic       iic_finish,
    output logic [7:0] cur_vid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DWELL
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  tgt, tgt_nxt;
    logic [7:0]  cur_nxt, data_nxt;
    logic        start_nxt, done_nxt;
    logic [15:0] dcnt, dcnt_nxt;
    logic [8:0]  diff;
    logic [7:0]  mag, step_val, nxt;
    logic        timeout;

    assign target_rdy = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

    // 9-bit difference keeps the sign; clamping the step to |diff| prevents overshoot and wrap
    assign diff     = {1'b0, tgt} - {1'b0, cur_vid};
    assign mag      = diff[8] ? 8'(~diff + 9'd1) : diff[7:0];
    assign step_val = (mag < STEP) ? mag : STEP;
    assign nxt      = diff[8] ? (cur_vid - step_val) : (cur_vid + step_val);

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        cur_nxt   = cur_vid;
        data_nxt  = iic_data;
        dcnt_nxt  = dcnt;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (target_vld) begin
                    tgt_nxt = target;
                    if (target == cur_vid) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_STEP: begin
                data_nxt  = nxt;
                start_nxt = 1'b1;
                state_nxt = S_WAIT_LO;
            end
            // finish is still high the cycle after the start pulse, so first see it drop
            S_WAIT_LO: begin
                if (!iic_finish) begin
                    state_nxt = S_WAIT_HI;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (iic_finish) begin
                    cur_nxt = iic_data;
                    if (iic_data == tgt) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        dcnt_nxt  = DWELL;
                        state_nxt = S_DWELL;
                    end
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DWELL: begin
                if (dcnt == '0) begin
                    state_nxt = S_STEP;
                end else begin
                    dcnt_nxt = dcnt - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tgt       <= VID_INIT;
            cur_vid   <= VID_INIT;
            iic_data  <= VID_INIT;
            iic_start <= 1'b0;
            done      <= 1'b0;
            dcnt      <= '0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            cur_vid   <= cur_nxt;
            iic_data  <= data_nxt;
            iic_start <= start_nxt;
            done      <= done_nxt;
            dcnt      <= dcnt_nxt;
        end
    end

`ifdef IIC_VID_RAMP_TIMEOUT_EN
    logic [23:0] wcnt;
    logic        waiting;

    assign waiting = (state == S_WAIT_LO) || (state == S_WAIT_HI);
    assign timeout = waiting && (wcnt == TIMEOUT - 24'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (state_nxt != state) begin
            wcnt <= '0;
        end else if (waiting) begin
            wcnt <= wcnt + 24'd1;
        end
    end

    // a return to IDLE without done from a wait state can only be the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (target_vld && target_rdy) begin
            err <= 1'b0;
        end else if (timeout && state_nxt == S_IDLE && !done_nxt) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_iic_vid_ramp.sv
// Directed bench for iic_vid_ramp with a behavioural I2C master (finish drops 1 cycle after
// start and rises 20 cycles later).
`timescale 1ns/1ps
module tb_iic_vid_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] target = 8'h00;
    logic       target_vld = 1'b0;
    logic       target_rdy;
    logic [7:0] iic_data;
    logic       iic_start;
    logic       iic_finish;
    logic [7:0] cur_vid;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    iic_vid_ramp #(
        .STEP(8'd4),
        .DWELL(16'd8),
        .VID_INIT(8'h10),
        .TIMEOUT(24'd100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .target(target),
        .target_vld(target_vld),
        .target_rdy(target_rdy),
        .iic_data(iic_data),
        .iic_start(iic_start),
        .iic_finish(iic_finish),
        .cur_vid(cur_vid),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    logic mfin;
    int   mcnt;
    logic stuck = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mfin <= 1'b1;
            mcnt <= 0;
        end else if (iic_start) begin
            mfin <= 1'b0;
            mcnt <= 20;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mfin <= 1'b1;
        end
    end
    assign iic_finish = mfin && !stuck;

    int         n_st;
    int         st_cyc [8];
    logic [7:0] st_dat [8];
    int         n_dn;
    int         dn_cyc;
    int         n_glitch;
    logic       rdy_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // handshake in cycle 0; returns in cycle 1
    task automatic handshake(input logic [7:0] t);
        target     = t;
        target_vld = 1'b1;
        tick();
        target_vld = 1'b0;
    endtask

    // records write/done activity over cycles 1..ncyc; optional late request in cycle 10
    task automatic collect(input int ncyc, input bit inject);
        logic [7:0] prev;
        n_st     = 0;
        n_dn     = 0;
        dn_cyc   = -1;
        n_glitch = 0;
        rdy_seen = 1'b1;
        prev     = iic_data;
        for (int c = 1; c <= ncyc; c++) begin
            if (iic_start) begin
                if (n_st < 8) begin
                    st_cyc[n_st] = c;
                    st_dat[n_st] = iic_data;
                end
                n_st++;
            end else if (iic_data !== prev) begin
                n_glitch++;
            end
            prev = iic_data;
            if (done) begin
                n_dn++;
                dn_cyc = c;
            end
            if (inject && c == 10) begin
                target     = 8'h40;
                target_vld = 1'b1;
                rdy_seen   = target_rdy;
            end
            tick();
            target_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cur_vid !== 8'h10) begin errors++; $display("FAIL reset_cur_vid: got %h expected 10", cur_vid); end
        checks++; if (iic_data !== 8'h10) begin errors++; $display("FAIL reset_iic_data: got %h expected 10", iic_data); end
        checks++; if ({iic_start, done, err, busy, target_rdy} !== 5'b00001) begin
            errors++; $display("FAIL reset_flags: got start/done/err/busy/rdy=%b expected 00001", {iic_start, done, err, busy, target_rdy});
        end
    endtask

    task automatic test_up_ramp();
        handshake(8'h18);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_c1: got %b expected 1", busy); end
        collect(70, 1'b0);
        checks++; if (n_st !== 2) begin errors++; $display("FAIL up_nstarts: got %0d expected 2", n_st); end
        checks++; if (st_cyc[0] !== 2 || st_dat[0] !== 8'h14) begin
            errors++; $display("FAIL up_write0: got cyc %0d data %h expected cyc 2 data 14", st_cyc[0], st_dat[0]);
        end
        checks++; if (st_cyc[1] !== 34 || st_dat[1] !== 8'h18) begin
            errors++; $display("FAIL up_write1: got cyc %0d data %h expected cyc 34 data 18", st_cyc[1], st_dat[1]);
        end
        checks++; if (n_dn !== 1 || dn_cyc !== 56) begin
            errors++; $display("FAIL up_done: got count %0d cyc %0d expected count 1 cyc 56", n_dn, dn_cyc);
        end
        checks++; if (n_glitch !== 0) begin errors++; $display("FAIL up_data_stable: got %0d changes expected 0", n_glitch); end
        checks++; if (cur_vid !== 8'h18 || target_rdy !== 1'b1) begin
            errors++; $display("FAIL up_final: got cur_vid %h rdy %b expected 18 1", cur_vid, target_rdy);
        end
    endtask

    task automatic test_clamped_step();
        do_reset();
        handshake(8'h0E);
        collect(40, 1'b0);
        checks++; if (n_st !== 1 || st_dat[0] !== 8'h0E || st_cyc[0] !== 2) begin
            errors++; $display("FAIL clamp_write: got n %0d data %h cyc %0d expected n 1 data 0e cyc 2", n_st, st_dat[0], st_cyc[0]);
        end
        checks++; if (n_dn !== 1 || dn_cyc !== 24) begin
            errors++; $display("FAIL clamp_done: got count %0d cyc %0d expected count 1 cyc 24", n_dn, dn_cyc);
        end
        checks++; if (cur_vid !== 8'h0E) begin errors++; $display("FAIL clamp_cur_vid: got %h expected 0e", cur_vid); end
    endtask

    task automatic test_down_ramp();
        handshake(8'h05);
        collect(100, 1'b0);
        checks++; if (n_st !== 3) begin errors++; $display("FAIL down_nstarts: got %0d expected 3", n_st); end
        checks++; if (st_dat[0] !== 8'h0A || st_dat[1] !== 8'h06 || st_dat[2] !== 8'h05) begin
            errors++; $display("FAIL down_data: got %h %h %h expected 0a 06 05", st_dat[0], st_dat[1], st_dat[2]);
        end
        checks++; if (st_cyc[1] !== 34 || st_cyc[2] !== 66) begin
            errors++; $display("FAIL down_spacing: got cyc %0d %0d expected 34 66", st_cyc[1], st_cyc[2]);
        end
        checks++; if (n_dn !== 1 || dn_cyc !== 88 || cur_vid !== 8'h05) begin
            errors++; $display("FAIL down_done: got count %0d cyc %0d cur %h expected 1 88 05", n_dn, dn_cyc, cur_vid);
        end
    endtask

    task automatic test_equal_target();
        int busy_hi;
        do_reset();
        handshake(8'h10);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL eq_done_c1: got %b expected 1", done); end
        busy_hi = (busy === 1'b1) ? 1 : 0;
        collect(10, 1'b0);
        checks++; if (busy_hi !== 0 || n_st !== 0 || n_dn !== 1) begin
            errors++; $display("FAIL eq_quiet: got busy %0d starts %0d dones %0d expected 0 0 1", busy_hi, n_st, n_dn);
        end
    endtask

    task automatic test_ignored_request();
        do_reset();
        handshake(8'h18);
        collect(70, 1'b1);
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL ign_rdy: got %b expected 0", rdy_seen); end
        checks++; if (n_st !== 2 || st_dat[1] !== 8'h18) begin
            errors++; $display("FAIL ign_writes: got n %0d last %h expected 2 18", n_st, st_dat[1]);
        end
        checks++; if (n_dn !== 1 || cur_vid !== 8'h18) begin
            errors++; $display("FAIL ign_final: got dones %0d cur %h expected 1 18", n_dn, cur_vid);
        end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        handshake(8'h18);
        for (int c = 1; c < 10; c++) tick();
        checks++; if (busy !== 1'b1 || iic_finish !== 1'b0) begin
            errors++; $display("FAIL rstmid_inflight: got busy %b finish %b expected 1 0", busy, iic_finish);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cur_vid !== 8'h10 || iic_data !== 8'h10) begin
            errors++; $display("FAIL rstmid_vid: got cur %h data %h expected 10 10", cur_vid, iic_data);
        end
        checks++; if ({iic_start, done, err, busy, target_rdy} !== 5'b00001) begin
            errors++; $display("FAIL rstmid_flags: got start/done/err/busy/rdy=%b expected 00001", {iic_start, done, err, busy, target_rdy});
        end
        collect(30, 1'b0);
        checks++; if (n_dn !== 0 || n_st !== 0) begin
            errors++; $display("FAIL rstmid_quiet: got dones %0d starts %0d expected 0 0", n_dn, n_st);
        end
    endtask

    task automatic test_watchdog();
        int dn;
        do_reset();
        stuck = 1'b1;
        handshake(8'h18);
        dn = 0;
        for (int c = 1; c < 102; c++) begin
            if (done) dn++;
            tick();
        end
`ifdef IIC_VID_RAMP_TIMEOUT_EN
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL wd_before: got err %b busy %b expected 0 1", err, busy);
        end
        tick();
        if (done) dn++;
        checks++; if (err !== 1'b1 || target_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wd_fire: got err %b rdy %b busy %b expected 1 1 0", err, target_rdy, busy);
        end
        checks++; if (cur_vid !== 8'h10 || dn !== 0) begin
            errors++; $display("FAIL wd_state: got cur %h dones %0d expected 10 0", cur_vid, dn);
        end
        stuck = 1'b0;
        handshake(8'h14);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b expected 0", err); end
        collect(30, 1'b0);
        checks++; if (n_dn !== 1 || cur_vid !== 8'h14) begin
            errors++; $display("FAIL wd_recover: got dones %0d cur %h expected 1 14", n_dn, cur_vid);
        end
`else
        for (int c = 102; c < 150; c++) begin
            if (done) dn++;
            tick();
        end
        checks++; if (err !== 1'b0 || busy !== 1'b1 || dn !== 0) begin
            errors++; $display("FAIL nowd_wait: got err %b busy %b dones %0d expected 0 1 0", err, busy, dn);
        end
        checks++; if (cur_vid !== 8'h10) begin errors++; $display("FAIL nowd_cur: got %h expected 10", cur_vid); end
        do_reset();
        stuck = 1'b0;
`endif
    endtask

    initial begin
        tick();
        test_reset();
        test_up_ramp();
        test_clamped_step();
        test_down_ramp();
        test_equal_target();
        test_ignored_request();
        test_reset_midwrite();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
